// File: rtl/cbus_arbiter.sv
// Round-robin arbiter: N upstream cache-bus masters onto one downstream memory-bus port.
// The whole transaction (single beat or burst) is granted to one master, until the beat
// flagged last completes. Each transaction is followed by one idle cycle.

package cbus_pkg;

  // len is the beat count minus one (0 = single beat).
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

`ifndef ASSERT
`define ASSERT(name, prop, clk, rst) \
  name: assert property (@(posedge clk) disable iff (rst) (prop));
`endif

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned IDX_W       = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_MASTERS],
  output cbus_resp_t iresps [NUM_MASTERS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W:0]   cand;

  // Find the first valid master scanning from rr_ptr with wrap-around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NUM_MASTERS)) begin
        cand = cand - (IDX_W + 1)'(NUM_MASTERS);
      end
      if (!pick_found && ireqs[cand[IDX_W-1:0]].valid) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Next-state logic plus combinational request/response routing.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    oreq        = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      iresps[i] = '0;
    end

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_idx_d = pick_idx;
          beat_cnt_d  = '0;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        // Grant is held until last even if the master drops valid; valid passes through.
        oreq                = ireqs[grant_idx_q];
        iresps[grant_idx_q] = oresp;
        if (oresp.ready) begin
          if (beat_cnt_q != 8'hff) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
          if (oresp.last) begin
            rr_ptr_d = (grant_idx_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx_q + 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; an aborted transaction is simply dropped on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

`ifndef SYNTHESIS
  // Beat count must agree with the request length when downstream signals last.
  `ASSERT(burst_len_matches,
          !(state_q == StBusy && oresp.ready && oresp.last) ||
          (({1'b0, beat_cnt_q} + 9'd1) == ({1'b0, oreq.len} + 9'd1)),
          clk, reset)
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed self-checking bench for cbus_arbiter (2-master and 3-master instances).

module tb_cbus_arbiter;
  import cbus_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  cbus_req_t  ireqs   [2];
  cbus_resp_t iresps  [2];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  cbus_req_t  ireqs3  [3];
  cbus_resp_t iresps3 [3];
  cbus_req_t  oreq3;
  cbus_resp_t oresp3;

  int n_chk  = 0;
  int n_fail = 0;
  int beats  = 0;

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_MASTERS(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .ireqs  (ireqs),
    .iresps (iresps),
    .oreq   (oreq),
    .oresp  (oresp)
  );

  cbus_arbiter #(.NUM_MASTERS(3)) dut3 (
    .clk    (clk),
    .reset  (reset),
    .ireqs  (ireqs3),
    .iresps (iresps3),
    .oreq   (oreq3),
    .oresp  (oresp3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cbus_req_t mkq(input logic wr, input logic [31:0] addr,
                                    input logic [7:0] len);
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.addr     = addr;
    r.len      = len;
    r.wdata    = '0;
    return r;
  endfunction

  function automatic cbus_resp_t mkr(input logic rdy, input logic lst, input logic [31:0] d);
    cbus_resp_t r;
    r.ready = rdy;
    r.last  = lst;
    r.data  = d;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) ireqs[i] = '0;
    for (int i = 0; i < 3; i++) ireqs3[i] = '0;
    oresp  = mkr(1'b1, 1'b1, 32'h0000_00aa);
    oresp3 = mkr(1'b1, 1'b1, 32'h0000_00bb);

    // Reset state: outputs zero even with a live downstream response.
    #1 reset = 1'b1;
    #2;
    chk("rst_oreq", oreq, '0);
    chk("rst_iresp0", iresps[0], '0);
    chk("rst_iresp1", iresps[1], '0);
    chk("rst_oreq3", oreq3, '0);
    chk("rst_rr", dut.rr_ptr_q, '0);
    tick();
    tick();
    reset  = 1'b0;
    oresp  = '0;
    oresp3 = '0;

    // 1: single DCache uncached read, response in 3rd busy cycle.
    ireqs[1] = mkq(1'b0, 32'h4060_0004, 8'd0);
    #1 chk("t1_idle_valid", oreq.valid, 1'b0);
    tick();
    #1;
    chk("t1_grant_valid", oreq.valid, 1'b1);
    chk("t1_addr", oreq.addr, 32'h4060_0004);
    chk("t1_m0_rdy_b1", iresps[0].ready, 1'b0);
    chk("t1_m1_rdy_b1", iresps[1].ready, 1'b0);
    tick();
    #1;
    chk("t1_valid_b2", oreq.valid, 1'b1);
    chk("t1_m0_rdy_b2", iresps[0].ready, 1'b0);
    tick();
    oresp = mkr(1'b1, 1'b1, 32'h0000_1234);
    #1;
    chk("t1_data", iresps[1].data, 32'h0000_1234);
    chk("t1_m1_rdy", iresps[1].ready, 1'b1);
    chk("t1_m1_last", iresps[1].last, 1'b1);
    chk("t1_m0_zero", iresps[0], '0);
    tick();
    ireqs[1] = '0;
    oresp    = '0;
    #1;
    chk("t1_back_idle", dut.state_q, '0);
    chk("t1_oreq_zero", oreq, '0);

    // 2: simultaneous 16-beat bursts after reset order; master 0 first.
    ireqs[0] = mkq(1'b0, 32'h0000_1000, 8'd15);
    ireqs[1] = mkq(1'b0, 32'h0000_2000, 8'd15);
    #1 chk("t2_idle_m1_rdy", iresps[1].ready, 1'b0);
    for (int b = 0; b < 16; b++) begin
      tick();
      oresp = mkr(1'b1, b == 15, 32'h100 + 32'(b));
      #1;
      chk("t2_m0_addr", oreq.addr, 32'h0000_1000);
      chk("t2_m0_data", iresps[0].data, 32'h100 + 32'(b));
      chk("t2_m1_wait", iresps[1].ready, 1'b0);
    end
    tick();
    ireqs[0] = '0;
    oresp    = '0;
    #1;
    chk("t2_gap_valid", oreq.valid, 1'b0);
    chk("t2_gap_m1_rdy", iresps[1].ready, 1'b0);
    tick();
    #1;
    chk("t2_m1_grant_valid", oreq.valid, 1'b1);
    chk("t2_m1_grant_addr", oreq.addr, 32'h0000_2000);
    for (int b = 0; b < 16; b++) begin
      if (b > 0) tick();
      oresp = mkr(1'b1, b == 15, 32'h200 + 32'(b));
      #1;
      chk("t2_m1_data", iresps[1].data, 32'h200 + 32'(b));
      chk("t2_m0_quiet", iresps[0].ready, 1'b0);
    end
    tick();
    ireqs[1] = '0;
    oresp    = '0;

    // 3: both masters hold valid for six single-beat transactions.
    ireqs[0] = mkq(1'b0, 32'h0000_1000, 8'd0);
    ireqs[1] = mkq(1'b0, 32'h0000_2000, 8'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      oresp = mkr(1'b1, 1'b1, 32'(k));
      #1;
      chk("t3_valid", oreq.valid, 1'b1);
      chk("t3_order", oreq.addr, (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
      chk("t3_loser_rdy", (k % 2 == 0) ? iresps[1].ready : iresps[0].ready, 1'b0);
      tick();
      oresp = '0;
      if (k == 5) begin
        ireqs[0] = '0;
        ireqs[1] = '0;
      end
      #1 chk("t3_turnaround", oreq.valid, 1'b0);
    end

    // 4: DCache writeback burst then fetch, separated by one idle cycle.
    ireqs[1] = mkq(1'b1, 32'h8000_0400, 8'd15);
    beats = 0;
    for (int b = 0; b < 16; b++) begin
      tick();
      ireqs[1].wdata = 32'(b);
      oresp = mkr(1'b1, b == 15, 32'h0);
      #1;
      chk("t4_wb_is_write", oreq.is_write, 1'b1);
      chk("t4_wb_wdata", oreq.wdata, 32'(b));
      if (oreq.valid && iresps[1].ready) beats++;
    end
    chk("t4_wb_beats", beats, 16);
    tick();
    ireqs[1] = mkq(1'b0, 32'h8000_0800, 8'd15);
    oresp    = '0;
    #1 chk("t4_idle_gap", oreq.valid, 1'b0);
    beats = 0;
    for (int b = 0; b < 16; b++) begin
      tick();
      oresp = mkr(1'b1, b == 15, 32'h500 + 32'(b));
      #1;
      chk("t4_fetch_is_write", oreq.is_write, 1'b0);
      chk("t4_fetch_addr", oreq.addr, 32'h8000_0800);
      chk("t4_fetch_data", iresps[1].data, 32'h500 + 32'(b));
      if (oreq.valid && iresps[1].ready) beats++;
    end
    chk("t4_fetch_beats", beats, 16);
    tick();
    ireqs[1] = '0;
    oresp    = '0;

    // 5: reset asserted at beat 5 of a 16-beat burst.
    ireqs[0] = mkq(1'b0, 32'h0000_3000, 8'd0);
    tick();
    oresp = mkr(1'b1, 1'b1, 32'h0);
    #1 chk("t5_single_addr", oreq.addr, 32'h0000_3000);
    tick();
    oresp    = '0;
    ireqs[0] = mkq(1'b0, 32'h0000_3100, 8'd15);
    #1 chk("t5_rr_advanced", dut.rr_ptr_q, 1'b1);
    for (int b = 0; b < 6; b++) begin
      tick();
      oresp = mkr(1'b1, 1'b0, 32'(b));
      #1;
    end
    chk("t5_beat_cnt", dut.beat_cnt_q, 8'd5);
    chk("t5_pre_rst_valid", oreq.valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5_async_valid", oreq.valid, 1'b0);
    chk("t5_async_iresp0", iresps[0], '0);
    ireqs[0] = '0;
    oresp    = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("t5_rr_reset", dut.rr_ptr_q, '0);
    chk("t5_cnt_reset", dut.beat_cnt_q, '0);
    chk("t5_oreq_reset", oreq, '0);
    ireqs[1] = mkq(1'b0, 32'h0000_4000, 8'd0);
    tick();
    #1;
    chk("t5_m1_valid", oreq.valid, 1'b1);
    chk("t5_m1_addr", oreq.addr, 32'h0000_4000);
    oresp = mkr(1'b1, 1'b1, 32'h55);
    #1 chk("t5_m1_data", iresps[1].data, 32'h55);
    tick();
    ireqs[1] = '0;
    oresp    = '0;

    // 6: three masters, 0 and 2 requesting; wrap from 2 back to 0.
    ireqs3[0] = mkq(1'b0, 32'h0000_1000, 8'd0);
    ireqs3[2] = mkq(1'b0, 32'h0000_5000, 8'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      oresp3 = mkr(1'b1, 1'b1, 32'h70 + 32'(k));
      #1;
      chk("t6_order", oreq3.addr, (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_5000);
      chk("t6_m1_zero", iresps3[1], '0);
      chk("t6_data", (k % 2 == 0) ? iresps3[0].data : iresps3[2].data, 32'h70 + 32'(k));
      tick();
      oresp3 = '0;
      if (k == 3) begin
        ireqs3[0] = '0;
        ireqs3[2] = '0;
      end
      #1 chk("t6_turnaround", oreq3.valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Round-robin arbiter between the per-core cache bus masters (ICache, DCache, and any later cbus master) and the single downstream memory-bus port. It sits directly downstream of the DCache `creq`/`cresp` port. It grants one master at a time for a whole transaction, single-beat or burst. It holds the grant until the beat flagged `last` completes, and routes responses back to the granted master only.

## Interface
Parameters:
- `NUM_MASTERS`, default 2: number of upstream cbus masters; legal range 2..8.
- `IDX_W`, default `$clog2(NUM_MASTERS)`: width of the grant index; never below 1.

Ports:
- `clk`  input  1: clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `ireqs`  input  `cbus_req_t [NUM_MASTERS]`: upstream requests. Index 0 = ICache, 1 = DCache.
- `iresps`  output  `cbus_resp_t [NUM_MASTERS]`: upstream responses.
- `oreq`  output  `cbus_req_t`: downstream request.
- `oresp`  input  `cbus_resp_t`: downstream response, with fields `ready`, `last`, `data`.

## Operation
State machine with two states, IDLE and BUSY, plus these registers:
- `grant_idx`: index of the granted master.
- `rr_ptr`: master with top priority at the next arbitration.
- `beat_cnt`: counts completed beats of the current transaction.

IDLE:
- `oreq` is all-zero; `oreq.valid` = 0.
- If any `ireqs[i].valid` is 1, select the first valid master scanning `rr_ptr`, `rr_ptr`+1, … modulo `NUM_MASTERS`.
- Latch that index into `grant_idx`, clear `beat_cnt`, go to BUSY.

BUSY:
- `oreq` = `ireqs[grant_idx]`, forwarded combinationally with every field unmodified.
- The arbiter latches no request fields. Each master must hold its request stable from `valid` until its `last` beat, which DCache does by construction.
- `iresps[grant_idx]` = `oresp`. Every other `iresps[j]` is all-zero: `ready` = 0, `last` = 0, `data` = 0.
- On `oresp.ready` = 1: `beat_cnt` += 1, 8-bit, saturating at 255.
- On `oresp.ready` = 1 and `oresp.last` = 1:
  - `rr_ptr` ← (`grant_idx` + 1) mod `NUM_MASTERS`. The wrap from `NUM_MASTERS`−1 goes to 0.
  - Next state is IDLE.
- If the granted master drops `valid` mid-transaction (protocol violation), the grant is still held until `last`. `oreq.valid` follows the master's valid.
- `last` from `oresp` is authoritative. `beat_cnt` is used for the simulation-only check below and never alters the grant.

Simultaneous requests: exactly one master wins, the one nearest `rr_ptr` in scan order. Losers keep `valid` high and see `ready` = 0. No request is dropped.

Simulation check (simulation only, using the codebase's ASSERT macro): at `last`, `beat_cnt`+1 must equal `oreq.len`+1.

Reset, asynchronous at any time including mid-burst:
- State ← IDLE.
- `grant_idx` ← 0, `rr_ptr` ← 0, `beat_cnt` ← 0.
- `oreq` ← all-zero; every `iresps[i]` ← all-zero.
- An aborted transaction is not resumed. Masters are reset by the same signal.

## Timing
- Arbitration latency: a request with `valid` = 1 in cycle t, while IDLE, gives `oreq.valid` = 1 in cycle t+1.
- Turnaround: one IDLE cycle follows every transaction. A master whose `last` beat completes in cycle t is granted again at the earliest in t+2.
- Response path (`oresp` → `iresps[grant_idx]`) is combinational: zero added latency per beat.
- Request path (`ireqs[grant_idx]` → `oreq`) is combinational in BUSY.
- Round-robin fairness: with all masters requesting continuously, each master waits at most `NUM_MASTERS`−1 transactions.
- Output reset values: `oreq` = 0, `iresps` = 0.

## Test plan
- Single DCache uncached read: `ireqs[1]` has `valid` = 1, `len` = MLEN1, `addr` = 0x4060_0004; downstream `ready` and `last` arrive in the 3rd BUSY cycle with `data` = 0x1234 → `oreq.valid` rises 1 cycle after the request, `iresps[1].data` = 0x1234, `iresps[0].ready` = 0 throughout, state returns to IDLE.
- Simultaneous requests after reset (`rr_ptr` = 0), both masters valid with 16-beat bursts → master 0 is granted first. Master 1 is granted exactly 2 cycles after master 0's `last`. Master 1 sees no `ready` before its grant.
- Back-to-back: both masters hold `valid` for 6 transactions → the grant order is 0,1,0,1,0,1.
- Writeback followed by fetch: DCache WRITEBACK burst, then FETCH at address 0x8000_0800 → two separate grants with an IDLE cycle between them. `oreq.is_write` = 1 for the first burst and 0 for the second, with all 16 beats forwarded each time.
- Reset asserted at beat 5 of a 16-beat burst → `oreq.valid` = 0 asynchronously, before the next edge. After reset release, a new request from master 1 is granted normally, and `rr_ptr` = 0.
- `NUM_MASTERS` = 3, with masters 0 and 2 requesting → the order alternates 0,2,0,2 and master 1's response stays zero.
